// File: rtl/lwe_dot_acc.sv
// lwe_dot_acc: signed dot-product accumulator producing the LWE body
// b = sum(+/- a_i*s_i) + e over N_TERMS products, modulo 2^DATA_WIDTH.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    product handshake (products dropped when in_ready=0)
//   in_data, in_neg      product word and subtract flag
//   noise                error sample, captured in the FIN cycle
//   out_valid/out_ready  result handshake
//   out_data             LWE body, stable while out_valid is high
module lwe_dot_acc #(
    parameter int DATA_WIDTH = 32,
    parameter int n_WIDTH    = 8,
    parameter int N_TERMS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_neg,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        ACC = 2'd0,
        FIN = 2'd1,
        OUT = 2'd2
    } state_t;

    localparam logic [n_WIDTH-1:0] LAST = n_WIDTH'(N_TERMS - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [n_WIDTH-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        unique case (state_q)
            ACC: begin
                if (in_valid) begin
                    acc_d = in_neg ? (acc_q - in_data)
                                   : (acc_q + in_data);
                    if (count_q == LAST) begin
                        // Counter clears here so it never reaches N_TERMS.
                        count_d = '0;
                        state_d = FIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            FIN: begin
                out_data_d = acc_q + noise;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
        // Handshake flags are registered copies of the next state, so
        // no input reaches an output combinationally.
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == OUT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lwe_dot_acc.sv
// Testbench for lwe_dot_acc with N_TERMS=4: directed scenarios plus
// randomized transactions checked against a plain-arithmetic model.
module tb_lwe_dot_acc;

    localparam int DW = 32;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_neg = 1'b0;
    logic          in_ready;
    logic [DW-1:0] noise = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lwe_dot_acc #(
        .DATA_WIDTH(DW),
        .n_WIDTH(8),
        .N_TERMS(NT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_neg(in_neg),
        .in_ready(in_ready),
        .noise(noise),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready)
    );

    // Reference: b = e + sum of signed terms, wrapping at 2^32.
    function automatic logic [DW-1:0] model_body(
        input logic [DW-1:0] t[NT],
        input bit            ng[NT],
        input logic [DW-1:0] e
    );
        longint s;
        s = longint'(e);
        for (int i = 0; i < NT; i++)
            s = ng[i] ? s - longint'(t[i]) : s + longint'(t[i]);
        return s[DW-1:0];
    endfunction

    // Present one term after `gap` idle cycles; returns 1 us after the
    // edge that accepted it, with in_valid dropped again.
    task automatic feed(input logic [DW-1:0] d, input bit n,
                        input int gap);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_neg   = n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b data=%h want 1 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [DW-1:0] t[NT] = '{32'd1, 32'd2, 32'd3, 32'd4};
        bit ng[NT] = '{0, 0, 0, 0};
        logic [DW-1:0] exp;
        noise = 0;
        out_ready = 1'b1;
        exp = model_body(t, ng, noise);
        for (int i = 0; i < NT; i++) feed(t[i], ng[i], 0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_fin: rdy=%b vld=%b want 0 0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_out: vld=%b data=%h rdy=%b want 1 %h 0",
                     out_valid, out_data, in_ready, exp);
        end
        n_checks++;
        if (exp !== 32'h0000000A) begin
            n_fail++;
            $display("FAIL basic_model: got %h want 0000000a", exp);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ret: vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic run_txn(input string nm,
                           input logic [DW-1:0] t[NT],
                           input bit ng[NT],
                           input logic [DW-1:0] e,
                           input int gap,
                           input logic [DW-1:0] want);
        bit ok;
        noise = e;
        for (int i = 0; i < NT; i++) feed(t[i], ng[i], gap);
        wait_out(ok);
        n_checks++;
        if (!ok || out_data !== want) begin
            n_fail++;
            $display("FAIL %s: ok=%b data=%h want %h", nm, ok, out_data, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sign_noise;
        logic [DW-1:0] t[NT] = '{32'd1, 32'd2, 32'd3, 32'd4};
        bit ng[NT] = '{0, 1, 0, 0};
        run_txn("sign_noise", t, ng, 32'h10, 0, 32'h00000016);
    endtask

    task automatic test_wrap;
        logic [DW-1:0] t1[NT] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0};
        logic [DW-1:0] t2[NT] = '{32'd0, 32'd0, 32'd0, 32'd1};
        bit n1[NT] = '{0, 0, 0, 0};
        bit n2[NT] = '{0, 0, 0, 1};
        run_txn("wrap_up", t1, n1, 32'h0, 0, 32'h00000001);
        run_txn("wrap_down", t2, n2, 32'h0, 0, 32'hFFFFFFFF);
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] t[NT] = '{32'd1, 32'd1, 32'd1, 32'd1};
        logic [DW-1:0] s7[NT] = '{32'd7, 32'd7, 32'd7, 32'd7};
        bit ng[NT] = '{0, 0, 0, 0};
        logic [DW-1:0] exp;
        bit ok;
        noise = 0;
        out_ready = 1'b0;
        exp = model_body(t, ng, noise);
        for (int i = 0; i < NT; i++) feed(t[i], ng[i], 0);
        wait_out(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_wait: out_valid never rose");
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd7;
        in_neg   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b data=%h rdy=%b want 1 %h 0",
                         c, out_valid, out_data, in_ready, exp);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        run_txn("bp_next", s7, ng, 32'h0, 0, 32'h0000001C);
    endtask

    task automatic test_gapped;
        logic [DW-1:0] t[NT] = '{32'd5, 32'd5, 32'd5, 32'd5};
        bit ng[NT] = '{0, 0, 0, 0};
        run_txn("gapped", t, ng, 32'h0, 3, 32'h00000014);
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] t[NT] = '{32'd5, 32'd5, 32'd5, 32'd5};
        bit ng[NT] = '{0, 0, 0, 0};
        noise = 0;
        feed(32'd9, 1'b0, 0);
        feed(32'd9, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: rdy=%b vld=%b data=%h want 1 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        run_txn("rst_after", t, ng, 32'h0, 0, 32'h00000014);
    endtask

    task automatic test_random;
        logic [DW-1:0] t[NT];
        bit ng[NT];
        logic [DW-1:0] e, exp;
        bit ok;
        int stall;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < NT; i++) begin
                t[i]  = $urandom;
                ng[i] = 1'($urandom_range(0, 1));
            end
            e     = $urandom;
            stall = $urandom_range(0, 3);
            exp   = model_body(t, ng, e);
            noise = e;
            out_ready = (stall == 0);
            for (int i = 0; i < NT; i++)
                feed(t[i], ng[i], $urandom_range(0, 2));
            wait_out(ok);
            n_checks++;
            if (!ok || out_data !== exp) begin
                n_fail++;
                $display("FAIL rand%0d: ok=%b data=%h want %h",
                         k, ok, out_data, exp);
            end
            repeat (stall) @(posedge clk);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_noise();
        test_wrap();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lwe_dot_acc.md
Name: lwe_dot_acc

Overview:
- Downstream consumer of the pipelined 32-bit torus multiplier (Mult64) in the CGGI key-generation datapath.
- Accepts a stream of signed products a_i·s_i and accumulates N_TERMS of them modulo 2^DATA_WIDTH, adding or subtracting each one according to a per-term sign flag for the negacyclic wrap.
- Adds a sampled noise word, then presents the LWE body b = Σ±a_i·s_i + e on a valid/ready output.
- Produces one result per N_TERMS accepted products, then returns to accumulation.

Parameters:
- DATA_WIDTH, 32, width of products, noise, accumulator and result (torus word).
- n_WIDTH, 8, width of the term counter; must satisfy 2^n_WIDTH >= N_TERMS.
- N_TERMS, 16, products summed per result; legal range 1..2^n_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product word valid this cycle.
- in_data  in  DATA_WIDTH  signed product from Mult64.out.
- in_neg  in  1  1 = subtract in_data, 0 = add.
- in_ready  out  1  block accepts a product this cycle.
- noise  in  DATA_WIDTH  error sample e, sampled only in FIN state.
- out_valid  out  1  result available.
- out_data  out  DATA_WIDTH  LWE body b.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Reset (asynchronous, any state): state=ACC, acc=0, count=0, out_valid=0, out_data=0, in_ready=1.
- Interface rule: one clock, reset asynchronous and active-high, ports named clk and rst.
- in_ready and out_valid are registered, decoded from state only. There is no combinational path from any input to any output.
- Mult64 has no backpressure, so the upstream controller must stall multiplier issue when in_ready=0. A product presented while in_ready=0 is dropped and does not change state.
- Arithmetic: every add and subtract is modulo 2^DATA_WIDTH (natural wrap, no saturation, no overflow flag). Subtraction is two's-complement.
- States:
  - ACC: in_ready=1, out_valid=0. On in_valid: acc <= acc + in_data (in_neg=0) or acc − in_data (in_neg=1); count <= count+1. If count == N_TERMS−1 at that edge, go to FIN; otherwise stay in ACC. Without in_valid, hold.
  - FIN (exactly 1 cycle): in_ready=0. out_data <= acc + noise, out_valid <= 1, go to OUT.
  - OUT: in_ready=0, out_valid=1, out_data stable. On out_ready: out_valid <= 0, acc <= 0, count <= 0, in_ready <= 1, go to ACC. Otherwise hold indefinitely.
- Latency: the last term is accepted at edge k; out_valid is high from edge k+1 (FIN→OUT transition). With out_ready tied high, the next term can be accepted at edge k+3. Peak throughput is N_TERMS terms per N_TERMS+2 cycles.
- N_TERMS=1: every accepted term goes directly to FIN.
- in_valid during FIN or OUT is ignored. out_ready outside OUT is ignored.
- Reset mid-accumulation or mid-OUT discards the partial sum and any pending result. No partial output is emitted.
- Counter width must not wrap before N_TERMS; count never exceeds N_TERMS−1.

Test Plan:
- Basic add (N_TERMS=4, noise=0, out_ready=1): terms 1,2,3,4, all in_neg=0 -> out_valid one cycle after last-term edge, out_data=0x0000000A, in_ready low for 2 cycles.
- Sign and noise: terms 1,2,3,4 with in_neg only on term 2, noise=0x00000010 -> out_data=0x00000016.
- Wrap-around: terms 0xFFFFFFFF, 0x00000002, 0, 0 with noise=0 -> out_data=0x00000001; then terms 0,0,0,1 with in_neg=1 on term 4 -> out_data=0xFFFFFFFF.
- Backpressure: after the result, hold out_ready=0 for 5 cycles while driving in_valid=1 with data 7 -> out_valid and out_data stay constant, in_ready=0, no term counted. Release out_ready -> next 4 terms of 7 give 0x0000001C.
- Gapped input: terms 5,5,5,5 with in_valid low for 3 cycles between terms -> out_data=0x00000014; idle cycles do not change acc.
- Reset mid-operation: accept terms 9,9, assert rst asynchronously between edges -> outputs immediately reach reset values. After release, terms 5,5,5,5 -> out_data=0x00000014.
